load_store_unit: RTL and testbench

//  Memory-access stage directly downstream of the ALU: takes the ALU result as an effective address, runs one data-memory bus transaction, and returns a sign/zero-extended load value.
//  - Byte-lane alignment: store data replicated per lane, byte strobes generated from addr[1:0].
//  - Stalls the pipeline while the access is outstanding; pulses done when the result is valid.

---
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: one data-bus transaction per start, with byte-lane alignment and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of truncating the address.
module load_store_unit #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] alu_out_i,
    input  logic [WIDTH-1:0] store_data_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] load_data_o,
    output logic             err_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic [3:0]       mem_wstrb_o,
    input  logic             mem_ready_i,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic             err_q, err_d;
    logic [31:0]      tcnt_q, tcnt_d;

    logic             access;
    logic             illegal;
    logic             misalign;
    logic [WIDTH-1:0] lane_wdata;
    logic [3:0]       lane_wstrb;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [WIDTH-1:0] rd_ext;

    assign access  = mem_read_i | mem_write_i;
    // Stores have no unsigned variants, so any funct3[2] on a store is illegal.
    assign illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) ||
                     (mem_write_i && funct3_i[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((funct3_i[1:0] == 2'b01) && alu_out_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (alu_out_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        case (funct3_i[1:0])
            2'b00: begin
                lane_wdata = {4{store_data_i[7:0]}};
                lane_wstrb = 4'b0001 << alu_out_i[1:0];
            end
            2'b01: begin
                lane_wdata = {2{store_data_i[15:0]}};
                lane_wstrb = 4'b0011 << {alu_out_i[1], 1'b0};
            end
            default: begin
                lane_wdata = store_data_i;
                lane_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    rd_byte = mem_rdata_i[7:0];
            2'd1:    rd_byte = mem_rdata_i[15:8];
            2'd2:    rd_byte = mem_rdata_i[23:16];
            default: rd_byte = mem_rdata_i[31:24];
        endcase
        rd_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (f3_q[1:0])
            2'b00:   rd_ext = {{24{~f3_q[2] & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{~f3_q[2] & rd_half[15]}}, rd_half};
            default: rd_ext = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            ld_q    <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        ld_d    = ld_q;
        err_d   = err_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && access) begin
                    addr_d  = {alu_out_i[WIDTH-1:2], 2'b00};
                    off_d   = alu_out_i[1:0];
                    f3_d    = funct3_i;
                    we_d    = mem_write_i;
                    wdata_d = lane_wdata;
                    wstrb_d = mem_write_i ? lane_wstrb : 4'b0000;
                    ld_d    = '0;
                    tcnt_d  = '0;
                    if (illegal || misalign) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StReq;
                        err_d   = 1'b0;
                    end
                end
            end
            StReq: begin
                if (mem_ready_i) begin
                    state_d = StDone;
                    ld_d    = we_q ? '0 : rd_ext;
                end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TimeoutLast)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    ld_d    = '0;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_o     = ((state_q == StIdle) && start_i && access) || (state_q == StReq);
        done_o      = (state_q == StDone);
        err_o       = (state_q == StDone) && err_q;
        load_data_o = ld_q;
        mem_req_o   = (state_q == StReq);
        mem_we_o    = (state_q == StReq) && we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_wstrb_o = (state_q == StReq) ? wstrb_q : 4'b0000;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected results queued at launch, checked at done.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_to, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_out, store_data;
    logic        stall, done, err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_ready_to;

    logic        to_stall, to_done, to_err, to_req, to_we;
    logic [31:0] to_ld, to_addr, to_wdata;
    logic [3:0]  to_wstrb;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] ld;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .TIMEOUT_CYCLES(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mem_read_i(mem_read),
        .mem_write_i(mem_write), .funct3_i(funct3), .alu_out_i(alu_out),
        .store_data_i(store_data), .stall_o(stall), .done_o(done), .load_data_o(load_data),
        .err_o(err), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_ready_i(mem_ready),
        .mem_rdata_i(mem_rdata)
    );

    load_store_unit #(.WIDTH(32), .TIMEOUT_CYCLES(4)) dut_to (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_to), .mem_read_i(mem_read),
        .mem_write_i(mem_write), .funct3_i(funct3), .alu_out_i(alu_out),
        .store_data_i(store_data), .stall_o(to_stall), .done_o(to_done), .load_data_o(to_ld),
        .err_o(to_err), .mem_req_o(to_req), .mem_we_o(to_we), .mem_addr_o(to_addr),
        .mem_wdata_o(to_wdata), .mem_wstrb_o(to_wstrb), .mem_ready_i(mem_ready_to),
        .mem_rdata_i(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input string tag, input logic wr, input logic rd, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                          input int delay, input logic bus, input logic [31:0] e_addr,
                          input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                          input logic [31:0] e_ld, input logic e_err);
        exp_t e, got;
        e.ld  = e_ld;
        e.err = e_err;
        sb_q.push_back(e);
        start = 1'b1; mem_write = wr; mem_read = rd; funct3 = f3; alu_out = a; store_data = sd;
        #1;
        check({tag, ":stall_launch"}, {31'd0, stall}, 32'd1);
        step();
        start = 1'b0; mem_write = 1'b0; mem_read = 1'b0; alu_out = 32'hDEAD_BEEF; store_data = '0;
        if (bus) begin
            for (int i = 0; i < delay; i++) begin
                check({tag, ":req_wait"}, {31'd0, mem_req}, 32'd1);
                check({tag, ":stall_wait"}, {31'd0, stall}, 32'd1);
                check({tag, ":addr_wait"}, mem_addr, e_addr);
                step();
            end
            check({tag, ":req"}, {31'd0, mem_req}, 32'd1);
            check({tag, ":we"}, {31'd0, mem_we}, {31'd0, wr});
            check({tag, ":addr"}, mem_addr, e_addr);
            check({tag, ":wstrb"}, {28'd0, mem_wstrb}, {28'd0, wr ? e_wstrb : 4'b0000});
            if (wr) check({tag, ":wdata"}, mem_wdata, e_wdata);
            mem_ready = 1'b1; mem_rdata = rdat;
            step();
            mem_ready = 1'b0; mem_rdata = $urandom;
        end else begin
            check({tag, ":no_req"}, {31'd0, mem_req}, 32'd0);
        end
        for (int i = 0; i < 4 && done !== 1'b1; i++) step();
        check({tag, ":done"}, {31'd0, done}, 32'd1);
        check({tag, ":stall_done"}, {31'd0, stall}, 32'd0);
        check({tag, ":sb_nonempty"}, {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check({tag, ":load_data"}, load_data, got.ld);
            check({tag, ":err"}, {31'd0, err}, {31'd0, got.err});
        end
        step();
        check({tag, ":done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_to = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; alu_out = '0; store_data = '0; mem_ready = 1'b0; mem_ready_to = 1'b0;
        mem_rdata = '0;
        #1;
        check("rst:stall", {31'd0, stall}, 32'd0);
        check("rst:done", {31'd0, done}, 32'd0);
        check("rst:err", {31'd0, err}, 32'd0);
        check("rst:req", {31'd0, mem_req}, 32'd0);
        check("rst:we", {31'd0, mem_we}, 32'd0);
        check("rst:addr", mem_addr, 32'd0);
        check("rst:wdata", mem_wdata, 32'd0);
        check("rst:wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst:load_data", load_data, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        access("lb", 0, 1, 3'b000, 32'h1003, 0, 32'h8011_2233, 0, 1, 32'h1000, 0, 0,
               32'hFFFF_FF80, 0);
        access("lbu", 0, 1, 3'b100, 32'h1001, 0, 32'h8011_2233, 0, 1, 32'h1000, 0, 0,
               32'h0000_0022, 0);
        access("lhu", 0, 1, 3'b101, 32'h2002, 0, 32'hBEEF_0000, 0, 1, 32'h2000, 0, 0,
               32'h0000_BEEF, 0);
        access("lh", 0, 1, 3'b001, 32'h2000, 0, 32'h1234_8001, 0, 1, 32'h2000, 0, 0,
               32'hFFFF_8001, 0);
        access("lw_slow", 0, 1, 3'b010, 32'h4000, 0, 32'hCAFE_F00D, 5, 1, 32'h4000, 0, 0,
               32'hCAFE_F00D, 0);
        access("sb", 1, 0, 3'b000, 32'h3001, 32'h0000_00AB, 0, 0, 1, 32'h3000, 32'hABAB_ABAB,
               4'b0010, 0, 0);
        access("sh", 1, 0, 3'b001, 32'h3002, 32'h1234_CDEF, 0, 0, 1, 32'h3000, 32'hCDEF_CDEF,
               4'b1100, 0, 0);
        access("sw_both", 1, 1, 3'b010, 32'h3004, 32'h1122_3344, 32'hFFFF_FFFF, 1, 1, 32'h3004,
               32'h1122_3344, 4'b1111, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        access("lw_mis", 0, 1, 3'b010, 32'h4002, 0, 32'h55AA_55AA, 0, 0, 0, 0, 0, 0, 1);
`else
        access("lw_mis", 0, 1, 3'b010, 32'h4002, 0, 32'h55AA_55AA, 0, 1, 32'h4000, 0, 0,
               32'h55AA_55AA, 0);
`endif
        access("ld_f3_111", 0, 1, 3'b111, 32'h5000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        access("st_f3_100", 1, 0, 3'b100, 32'h5000, 32'h1, 0, 0, 0, 0, 0, 0, 0, 1);

        // Start without a direction must be ignored.
        start = 1'b1; funct3 = 3'b010; alu_out = 32'h7000;
        #1;
        check("nodir:stall", {31'd0, stall}, 32'd0);
        step();
        start = 1'b0;
        check("nodir:req", {31'd0, mem_req}, 32'd0);
        check("nodir:done", {31'd0, done}, 32'd0);

        // Timeout instance: LW with mem_ready held low.
        start_to = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h5000;
        step();
        start_to = 1'b0; mem_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to:req_held", {31'd0, to_req}, 32'd1);
            step();
        end
        check("to:req_drop", {31'd0, to_req}, 32'd0);
        check("to:done", {31'd0, to_done}, 32'd1);
        check("to:err", {31'd0, to_err}, 32'd1);
        check("to:load_data", to_ld, 32'd0);
        step();
        check("to:done_pulse", {31'd0, to_done}, 32'd0);

        // Asynchronous reset while a request is outstanding.
        start = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h6000;
        step();
        start = 1'b0; mem_read = 1'b0;
        check("abort:req_before", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort:req", {31'd0, mem_req}, 32'd0);
        check("abort:stall", {31'd0, stall}, 32'd0);
        check("abort:addr", mem_addr, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        access("post_rst", 0, 1, 3'b000, 32'h1002, 0, 32'h0055_0000, 0, 1, 32'h1000, 0, 0,
               32'h0000_0055, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
